led_pattern_monitor: RTL and testbench

- Monitors an 8-bit LED frame stream and identifies which sequencer pattern is running.
- This is the receive/decode side of the LED sequencer: it decodes patterns that the sequencer generates.
- Sits on the sequencer output (tapped LED bus plus step strobe) for self-check and status reporting.
- Reports a locked pattern code, a lock flag and a break pulse when a locked pattern is violated.

---
 rtl/led_pattern_monitor.sv | 185 ++++++++++++++++++
 tb/tb_led_pattern_monitor.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_monitor.sv
// led_pattern_monitor
//   Watches the LED sequencer output bus and works out which pattern is running.
//   Each frame is compared against the previous one. The set of patterns that
//   still fit the recent steps is narrowed down over consecutive frames. Once a
//   single candidate has held for LOCK_COUNT steps, that pattern is reported as
//   locked.
//
//   Optional build macro: MPLS_PERIOD_MEAS_EN
//     When defined, an interval counter is built and period_out reports the
//     number of cycles between the last two frames.
//     When undefined, period_out is tied to 0.
//
//   Ports
//     clk_10MHz    in   system clock
//     rst          in   asynchronous active-high reset
//     frame_valid  in   one-cycle frame strobe
//     frame        in   [7:0] LED frame value
//     pattern_id   out  [2:0] 0 none, 1 rotl, 2 rotr, 3 up, 4 down, 5 toggle, 6 hold
//     locked       out  high while one pattern is locked
//     break_pulse  out  one-cycle pulse when a locked pattern is violated
//     period_out   out  [23:0] cycles between the last two frames
//
//   state  | meaning
//   EMPTY  | no reference frame yet; the next frame only seeds prev
//   TRACK  | narrowing candidates, not locked
//   LOCKED | exactly one candidate has held for LOCK_COUNT steps

module led_pattern_monitor #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned TIMEOUT    = 16777215
) (
    input  logic        clk_10MHz,
    input  logic        rst,
    input  logic        frame_valid,
    input  logic [7:0]  frame,
    output logic [2:0]  pattern_id,
    output logic        locked,
    output logic        break_pulse,
    output logic [23:0] period_out
);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0]  LOCK_TH  = 4'(LOCK_COUNT);
    // The counter reaches TIMEOUT on the edge that finds it at TIMEOUT-1.
    localparam logic [23:0] TO_LAST  = 24'(TIMEOUT - 1);

    state_t      state, state_n;
    logic [7:0]  prev, prev_n;
    logic [5:0]  cand, cand_n;
    logic [3:0]  streak, streak_n;
    logic [23:0] tcnt, tcnt_n;
    logic [2:0]  pid_n;
    logic        locked_n;
    logic        break_n;
    logic [5:0]  m;
    logic [5:0]  n;
    logic        timeout_hit;

    function automatic logic [2:0] cand_to_id(input logic [5:0] c);
        logic [2:0] id;
        id = 3'd0;
        for (int k = 0; k < 6; k++) begin
            if (c[k]) id = 3'(k + 1);
        end
        return id;
    endfunction

    always_comb begin
        m    = 6'd0;
        m[0] = $onehot(prev) && (frame == {prev[6:0], prev[7]});
        m[1] = $onehot(prev) && (frame == {prev[0], prev[7:1]});
        m[2] = (frame == 8'(prev + 8'd1));
        m[3] = (frame == 8'(prev - 8'd1));
        m[4] = (frame == ~prev);
        m[5] = (frame == prev);
        n    = cand & m;
    end

    // Timeout is never taken in EMPTY and always loses to a coincident frame.
    assign timeout_hit = (state != EMPTY) && !frame_valid && (tcnt >= TO_LAST);

    always_comb begin
        state_n  = state;
        prev_n   = prev;
        cand_n   = cand;
        streak_n = streak;
        pid_n    = pattern_id;
        locked_n = locked;
        break_n  = 1'b0;

        if (frame_valid)           tcnt_n = 24'd0;
        else if (tcnt != 24'hFFFFFF) tcnt_n = tcnt + 24'd1;
        else                       tcnt_n = tcnt;

        if (frame_valid) begin
            prev_n = frame;
            if (state == EMPTY) begin
                state_n = TRACK;
            end else begin
                if (m == 6'd0) begin
                    cand_n   = 6'b111111;
                    streak_n = 4'd0;
                end else if (n == 6'd0) begin
                    cand_n   = m;
                    streak_n = 4'd1;
                end else begin
                    cand_n   = n;
                    streak_n = (streak == 4'd15) ? 4'd15 : streak + 4'd1;
                end

                if ((streak_n >= LOCK_TH) && $onehot(cand_n)) begin
                    state_n  = LOCKED;
                    locked_n = 1'b1;
                    pid_n    = cand_to_id(cand_n);
                end else begin
                    state_n  = TRACK;
                    locked_n = 1'b0;
                    pid_n    = 3'd0;
                end

                // While LOCKED, cand holds the locked one-hot.
                break_n = (state == LOCKED) && (cand_n != cand);
            end
        end else if (timeout_hit) begin
            state_n  = EMPTY;
            cand_n   = 6'b111111;
            streak_n = 4'd0;
            locked_n = 1'b0;
            pid_n    = 3'd0;
        end
    end

    always_ff @(posedge clk_10MHz or posedge rst) begin
        if (rst) begin
            state       <= EMPTY;
            prev        <= 8'd0;
            cand        <= 6'b111111;
            streak      <= 4'd0;
            tcnt        <= 24'd0;
            pattern_id  <= 3'd0;
            locked      <= 1'b0;
            break_pulse <= 1'b0;
        end else begin
            state       <= state_n;
            prev        <= prev_n;
            cand        <= cand_n;
            streak      <= streak_n;
            tcnt        <= tcnt_n;
            pattern_id  <= pid_n;
            locked      <= locked_n;
            break_pulse <= break_n;
        end
    end

`ifdef MPLS_PERIOD_MEAS_EN
    logic [23:0] icnt;
    logic [23:0] period_q;

    always_ff @(posedge clk_10MHz or posedge rst) begin
        if (rst) begin
            icnt     <= 24'd0;
            period_q <= 24'd0;
        end else begin
            if (frame_valid)             icnt <= 24'd0;
            else if (icnt != 24'hFFFFFF) icnt <= icnt + 24'd1;

            // The frame-to-frame distance is one more than the idle count.
            if (frame_valid && (state != EMPTY))
                period_q <= (icnt == 24'hFFFFFF) ? icnt : icnt + 24'd1;
            else if (timeout_hit)
                period_q <= 24'd0;
        end
    end

    assign period_out = period_q;
`else
    assign period_out = 24'd0;
`endif

endmodule

// File: tb/tb_led_pattern_monitor.sv
module tb_led_pattern_monitor;

    logic        clk;
    logic        rst;
    logic        frame_valid;
    logic [7:0]  frame;
    logic [2:0]  pattern_id;
    logic        locked;
    logic        break_pulse;
    logic [23:0] period_out;

    int checks = 0;
    int errors = 0;

`ifdef MPLS_PERIOD_MEAS_EN
    localparam bit PM = 1'b1;
`else
    localparam bit PM = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]  pid;
        logic        lk;
        logic        brk;
        logic [23:0] per;
    } exp_t;

    exp_t exp_q[$];
    logic fv_d;

    led_pattern_monitor #(.LOCK_COUNT(4), .TIMEOUT(20)) dut (
        .clk_10MHz  (clk),
        .rst        (rst),
        .frame_valid(frame_valid),
        .frame      (frame),
        .pattern_id (pattern_id),
        .locked     (locked),
        .break_pulse(break_pulse),
        .period_out (period_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] per(input int v);
        return PM ? 24'(v) : 24'd0;
    endfunction

    // Outputs reflect a frame one cycle after it is sampled.
    always @(posedge clk or posedge rst) begin
        if (rst) fv_d <= 1'b0;
        else     fv_d <= frame_valid;
    end

    always @(negedge clk) begin
        exp_t e;
        if (fv_d) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got pid=%0d locked=%0b brk=%0b, required none queued",
                         pattern_id, locked, break_pulse);
            end else begin
                e = exp_q.pop_front();
                if (pattern_id !== e.pid || locked !== e.lk || break_pulse !== e.brk || period_out !== e.per) begin
                    errors++;
                    $display("FAIL frame_out: got pid=%0d locked=%0b brk=%0b per=%0d, required pid=%0d locked=%0b brk=%0b per=%0d",
                             pattern_id, locked, break_pulse, period_out, e.pid, e.lk, e.brk, e.per);
                end
            end
        end else if (!rst) begin
            checks++;
            if (break_pulse !== 1'b0) begin
                errors++;
                $display("FAIL idle_break: got break_pulse=%0b, required 0", break_pulse);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    // Called at a negedge; returns at a negedge, gap cycles after the frame strobe.
    task automatic send_frame(input logic [7:0] f, input int gap,
                              input logic [2:0] pid, input logic lk,
                              input logic brk, input logic [23:0] p);
        exp_t e;
        e.pid = pid; e.lk = lk; e.brk = brk; e.per = p;
        exp_q.push_back(e);
        frame       = f;
        frame_valid = 1'b1;
        @(negedge clk);
        frame_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] vec [5];

        rst = 1'b1;
        frame_valid = 1'b0;
        frame = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_pid", 32'(pattern_id), 32'd0);
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_break", 32'(break_pulse), 32'd0);
        check("reset_period", 32'(period_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // rotl lock; 0x01->0x02 is ambiguous with up
        vec = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
        send_frame(vec[0], 3, 3'd0, 1'b0, 1'b0, 24'd0);
        for (int i = 1; i < 4; i++) send_frame(vec[i], 3, 3'd0, 1'b0, 1'b0, per(3));
        send_frame(vec[4], 3, 3'd1, 1'b1, 1'b0, per(3));

        // up counter through the 0xFF->0x00 wrap
        do_reset();
        vec = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01};
        send_frame(vec[0], 3, 3'd0, 1'b0, 1'b0, 24'd0);
        for (int i = 1; i < 4; i++) send_frame(vec[i], 3, 3'd0, 1'b0, 1'b0, per(3));
        send_frame(vec[4], 3, 3'd3, 1'b1, 1'b0, per(3));

        // toggle lock, break, relock as up
        do_reset();
        vec = '{8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55};
        send_frame(vec[0], 3, 3'd0, 1'b0, 1'b0, 24'd0);
        for (int i = 1; i < 4; i++) send_frame(vec[i], 3, 3'd0, 1'b0, 1'b0, per(3));
        send_frame(vec[4], 3, 3'd5, 1'b1, 1'b0, per(3));
        send_frame(8'h13, 3, 3'd0, 1'b0, 1'b1, per(3));
        send_frame(8'h14, 3, 3'd0, 1'b0, 1'b0, per(3));
        send_frame(8'h15, 3, 3'd0, 1'b0, 1'b0, per(3));
        send_frame(8'h16, 3, 3'd0, 1'b0, 1'b0, per(3));
        send_frame(8'h17, 3, 3'd3, 1'b1, 1'b0, per(3));

        // hold lock then timeout after 20 idle cycles
        do_reset();
        send_frame(8'h3C, 3, 3'd0, 1'b0, 1'b0, 24'd0);
        for (int i = 0; i < 3; i++) send_frame(8'h3C, 3, 3'd0, 1'b0, 1'b0, per(3));
        send_frame(8'h3C, 1, 3'd6, 1'b1, 1'b0, per(3));
        repeat (19) @(posedge clk);
        #1;
        check("pre_timeout_locked", 32'(locked), 32'd1);
        @(posedge clk);
        #1;
        check("timeout_locked", 32'(locked), 32'd0);
        check("timeout_pid", 32'(pattern_id), 32'd0);
        check("timeout_break", 32'(break_pulse), 32'd0);
        check("timeout_period", 32'(period_out), 32'd0);
        @(negedge clk);
        send_frame(8'h3C, 3, 3'd0, 1'b0, 1'b0, 24'd0);
        for (int i = 0; i < 3; i++) send_frame(8'h3C, 3, 3'd0, 1'b0, 1'b0, per(3));
        send_frame(8'h3C, 3, 3'd6, 1'b1, 1'b0, per(3));

        // async reset while locked, then back-to-back frames that must not lock
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_locked", 32'(locked), 32'd0);
        check("async_rst_pid", 32'(pattern_id), 32'd0);
        check("async_rst_break", 32'(break_pulse), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_frame(8'h3C, 1, 3'd0, 1'b0, 1'b0, 24'd0);
        for (int i = 0; i < 3; i++) send_frame(8'h3C, 1, 3'd0, 1'b0, 1'b0, per(1));
        @(negedge clk);

        // frames 7 cycles apart
        do_reset();
        send_frame(8'h81, 7, 3'd0, 1'b0, 1'b0, 24'd0);
        send_frame(8'h03, 4, 3'd0, 1'b0, 1'b0, per(7));
        check("period_held", 32'(period_out), 32'(per(7)));
        repeat (3) @(negedge clk);
        send_frame(8'h06, 3, 3'd0, 1'b0, 1'b0, per(7));

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
